// File: rtl/segre_pkg.sv
// Shared types and helpers for the segre core memory path.
package segre_pkg;

    localparam int unsigned ADDR_SIZE = 32;
    localparam int unsigned WORD_SIZE = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ERR  = 2'b10
    } arb_state_e;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Only the two low address bits decide alignment for BYTE/HALF/WORD.
    function automatic logic is_misaligned(logic [1:0] addr_lsb, memop_data_type_e data_type);
        case (data_type)
            HALF:    return addr_lsb[0];
            WORD:    return |addr_lsb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/segre_rr_picker.sv
// Combinational picker: first asserted request at/after ptr, wrapping to 0.
// A pointer of zero degenerates to fixed lowest-index priority.
module segre_rr_picker #(
    parameter int unsigned N_PORTS = 2
) (
    input  logic [N_PORTS-1:0]         req_vec,
    input  logic [$clog2(N_PORTS)-1:0] ptr,
    output logic [N_PORTS-1:0]         grant_oh,
    output logic [$clog2(N_PORTS)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int unsigned IDX_W = $clog2(N_PORTS);

    int unsigned cand;

    // Scan ports starting at ptr; the first asserted one wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            if (!grant_any && req_vec[IDX_W'(cand)]) begin
                grant_any                 = 1'b1;
                grant_idx                 = IDX_W'(cand);
                grant_oh[IDX_W'(cand)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// N-port arbiter multiplexing stage requesters onto the single memory port.
// Port 0 is the MEM stage, port 1 the IF stage. Fixed or round-robin priority,
// misaligned requests are rejected without touching memory, and an optional
// watchdog aborts accesses the memory never completes.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned ARB_MODE = ARB_FIXED,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic                           clk_i,
    input  logic                           rsn_i,
    input  logic [N_PORTS-1:0]             req_i,
    input  logic [N_PORTS*ADDR_SIZE-1:0]   req_addr_i,
    input  logic [N_PORTS-1:0]             req_wr_i,
    input  logic [N_PORTS*WORD_SIZE-1:0]   req_wr_data_i,
    input  memop_data_type_e [N_PORTS-1:0] req_type_i,
    output logic [N_PORTS-1:0]             ack_o,
    output logic [N_PORTS-1:0]             err_o,
    output logic [WORD_SIZE-1:0]           rd_data_o,
    output logic                           busy_o,
    output logic [ADDR_SIZE-1:0]           mem_addr_o,
    output logic                           mem_rd_o,
    output logic                           mem_wr_o,
    output logic [WORD_SIZE-1:0]           mem_wr_data_o,
    output memop_data_type_e               mem_data_type_o,
    input  logic [WORD_SIZE-1:0]           mem_rd_data_i,
    input  logic                           mem_ready_i
);

    localparam int unsigned IDX_W = $clog2(N_PORTS);
    localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    arb_state_e           state_q;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [WD_W-1:0]      wd_cnt_q;
    logic [WORD_SIZE-1:0] rd_data_q;

    logic [IDX_W-1:0]     pick_ptr;
    logic [N_PORTS-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 win_misaligned;

    logic [ADDR_SIZE-1:0] g_addr;
    logic                 g_wr;
    logic [WORD_SIZE-1:0] g_wr_data;
    memop_data_type_e     g_type;

    logic                 wd_expired;
    logic                 timeout_now;
    logic [IDX_W-1:0]     next_ptr;

    // Fixed priority simply pins the scan start to port 0.
    always_comb begin
        pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
    end

    segre_rr_picker #(
        .N_PORTS(N_PORTS)
    ) u_picker (
        .req_vec   (req_i),
        .ptr       (pick_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Alignment check on the port that would win arbitration this cycle.
    always_comb begin
        win_misaligned = 1'b0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (pick_oh[p]) begin
                win_misaligned = is_misaligned(req_addr_i[p*ADDR_SIZE +: 2], req_type_i[p]);
            end
        end
    end

    // Select the registered winner's request fields.
    always_comb begin
        g_addr    = '0;
        g_wr      = 1'b0;
        g_wr_data = '0;
        g_type    = WORD;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (grant_q == IDX_W'(p)) begin
                g_addr    = req_addr_i[p*ADDR_SIZE +: ADDR_SIZE];
                g_wr      = req_wr_i[p];
                g_wr_data = req_wr_data_i[p*WORD_SIZE +: WORD_SIZE];
                g_type    = req_type_i[p];
            end
        end
    end

    // Watchdog expiry and the pointer value following the current grant.
    always_comb begin
        wd_expired  = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);
        timeout_now = (state_q == BUSY) && !mem_ready_i && wd_expired;
        next_ptr    = (grant_q == IDX_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
    end

    // Memory-side drive and per-port completion pulses.
    always_comb begin
        ack_o           = '0;
        err_o           = '0;
        mem_addr_o      = '0;
        mem_rd_o        = 1'b0;
        mem_wr_o        = 1'b0;
        mem_wr_data_o   = '0;
        mem_data_type_o = WORD;
        if (state_q == BUSY) begin
            mem_addr_o      = g_addr;
            mem_wr_data_o   = g_wr_data;
            mem_data_type_o = g_type;
            mem_rd_o        = !g_wr && !timeout_now;
            mem_wr_o        = g_wr && !timeout_now;
        end
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (grant_q == IDX_W'(p)) begin
                ack_o[p] = (state_q == BUSY) && mem_ready_i;
                err_o[p] = timeout_now || (state_q == ERR);
            end
        end
    end

    // Load data passes straight through on ack and is held afterwards.
    always_comb begin
        rd_data_o = (|ack_o) ? mem_rd_data_i : rd_data_q;
        busy_o    = (state_q != IDLE);
    end

    // Arbitration FSM, round-robin pointer, watchdog and read-data hold.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            wd_cnt_q  <= '0;
            rd_data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q  <= pick_idx;
                        wd_cnt_q <= '0;
                        state_q  <= win_misaligned ? ERR : BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        rd_data_q <= mem_rd_data_i;
                        rr_ptr_q  <= next_ptr;
                        state_q   <= IDLE;
                    end else if (timeout_now) begin
                        rr_ptr_q  <= next_ptr;
                        state_q   <= IDLE;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_q  <= wd_cnt_q + 1'b1;
                    end
                end
                ERR: begin
                    rr_ptr_q <= next_ptr;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Requesters must hold req_i until their ack/err pulse.
    a_req_held: assert property (
        @(posedge clk_i) disable iff (!rsn_i)
        (state_q != IDLE) |-> req_i[grant_q]
    );

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: two instances (2-port fixed with watchdog,
// 4-port round-robin without), a transaction-level reference model compared
// every cycle, plus directed literal expectations.
module tb_segre_mem_arbiter;
    import segre_pkg::*;

    localparam int NP   [2] = '{2, 4};
    localparam int MODE [2] = '{0, 1};
    localparam int TMO  [2] = '{8, 0};

    logic clk = 1'b0;
    logic rsn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus, indexed [dut][port]
    logic [3:0]       req  [2];
    logic [31:0]      addr [2][4];
    logic [3:0]       wr   [2];
    logic [31:0]      wdat [2][4];
    memop_data_type_e typ  [2][4];
    logic [31:0]      mrd  [2];
    logic             mrdy [2];

    // Collected outputs, indexed [dut]
    logic [3:0]       o_ack [2];
    logic [3:0]       o_err [2];
    logic [31:0]      o_rd  [2];
    logic             o_busy[2];
    logic [31:0]      o_maddr[2];
    logic             o_mrd [2];
    logic             o_mwr [2];
    logic [31:0]      o_mwd [2];
    memop_data_type_e o_typ [2];

    logic [1:0]  a_req, a_wr, a_ack, a_err;
    logic [63:0] a_addr, a_wdat;
    memop_data_type_e [1:0] a_typ;
    logic [31:0] a_rd, a_maddr, a_mwd;
    logic        a_busy, a_mrd, a_mwr;
    memop_data_type_e a_mtyp;

    logic [3:0]   b_req, b_wr, b_ack, b_err;
    logic [127:0] b_addr, b_wdat;
    memop_data_type_e [3:0] b_typ;
    logic [31:0]  b_rd, b_maddr, b_mwd;
    logic         b_busy, b_mrd, b_mwr;
    memop_data_type_e b_mtyp;

    always_comb begin
        a_req  = req[0][1:0];
        a_wr   = wr[0][1:0];
        a_addr = {addr[0][1], addr[0][0]};
        a_wdat = {wdat[0][1], wdat[0][0]};
        a_typ[0] = typ[0][0];
        a_typ[1] = typ[0][1];
        b_req  = req[1];
        b_wr   = wr[1];
        b_addr = {addr[1][3], addr[1][2], addr[1][1], addr[1][0]};
        b_wdat = {wdat[1][3], wdat[1][2], wdat[1][1], wdat[1][0]};
        for (int p = 0; p < 4; p++) b_typ[p] = typ[1][p];
    end

    always_comb begin
        o_ack[0] = {2'b00, a_ack};  o_ack[1] = b_ack;
        o_err[0] = {2'b00, a_err};  o_err[1] = b_err;
        o_rd[0] = a_rd;             o_rd[1] = b_rd;
        o_busy[0] = a_busy;         o_busy[1] = b_busy;
        o_maddr[0] = a_maddr;       o_maddr[1] = b_maddr;
        o_mrd[0] = a_mrd;           o_mrd[1] = b_mrd;
        o_mwr[0] = a_mwr;           o_mwr[1] = b_mwr;
        o_mwd[0] = a_mwd;           o_mwd[1] = b_mwd;
        o_typ[0] = a_mtyp;          o_typ[1] = b_mtyp;
    end

    segre_mem_arbiter #(.N_PORTS(2), .ARB_MODE(ARB_FIXED), .TIMEOUT(8)) u_dut_a (
        .clk_i(clk), .rsn_i(rsn), .req_i(a_req), .req_addr_i(a_addr), .req_wr_i(a_wr),
        .req_wr_data_i(a_wdat), .req_type_i(a_typ), .ack_o(a_ack), .err_o(a_err),
        .rd_data_o(a_rd), .busy_o(a_busy), .mem_addr_o(a_maddr), .mem_rd_o(a_mrd),
        .mem_wr_o(a_mwr), .mem_wr_data_o(a_mwd), .mem_data_type_o(a_mtyp),
        .mem_rd_data_i(mrd[0]), .mem_ready_i(mrdy[0])
    );

    segre_mem_arbiter #(.N_PORTS(4), .ARB_MODE(ARB_RR), .TIMEOUT(0)) u_dut_b (
        .clk_i(clk), .rsn_i(rsn), .req_i(b_req), .req_addr_i(b_addr), .req_wr_i(b_wr),
        .req_wr_data_i(b_wdat), .req_type_i(b_typ), .ack_o(b_ack), .err_o(b_err),
        .rd_data_o(b_rd), .busy_o(b_busy), .mem_addr_o(b_maddr), .mem_rd_o(b_mrd),
        .mem_wr_o(b_mwr), .mem_wr_data_o(b_mwd), .mem_data_type_o(b_mtyp),
        .mem_rd_data_i(mrd[1]), .mem_ready_i(mrdy[1])
    );

    // ---------------- reference model ----------------
    // phase: 0 = waiting for a request, 1 = memory access, 2 = rejected access
    int          ph  [2] = '{0, 0};
    int          gp  [2] = '{0, 0};
    int          ptr [2] = '{0, 0};
    int          age [2] = '{0, 0};
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};

    function automatic int pick_port(int d);
        int start = (MODE[d] == 1) ? ptr[d] : 0;
        for (int i = 0; i < NP[d]; i++) begin
            int p = (start + i) % NP[d];
            if (req[d][p]) return p;
        end
        return -1;
    endfunction

    function automatic bit misaligned(logic [31:0] a, memop_data_type_e t);
        if (t == HALF) return (a % 2) != 0;
        if (t == WORD) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic bit tmo_now(int d);
        return ph[d] == 1 && !mrdy[d] && TMO[d] != 0 && age[d] == TMO[d] - 1;
    endfunction

    always @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            for (int d = 0; d < 2; d++) begin
                ph[d] <= 0; gp[d] <= 0; ptr[d] <= 0; age[d] <= 0; last_rd[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (ph[d] == 0) begin
                    if (pick_port(d) >= 0) begin
                        gp[d]  <= pick_port(d);
                        age[d] <= 0;
                        ph[d]  <= misaligned(addr[d][pick_port(d)], typ[d][pick_port(d)]) ? 2 : 1;
                    end
                end else if (ph[d] == 1) begin
                    if (mrdy[d]) begin
                        last_rd[d] <= mrd[d];
                        ph[d]      <= 0;
                        ptr[d]     <= (gp[d] + 1) % NP[d];
                    end else if (tmo_now(d)) begin
                        ph[d]  <= 0;
                        ptr[d] <= (gp[d] + 1) % NP[d];
                    end else begin
                        age[d] <= age[d] + 1;
                    end
                end else begin
                    ph[d]  <= 0;
                    ptr[d] <= (gp[d] + 1) % NP[d];
                end
            end
        end
    end

    function automatic logic [3:0] exp_ack(int d);
        return (ph[d] == 1 && mrdy[d]) ? (4'(1) << gp[d]) : 4'(0);
    endfunction
    function automatic logic [3:0] exp_err(int d);
        return (ph[d] == 2 || tmo_now(d)) ? (4'(1) << gp[d]) : 4'(0);
    endfunction
    function automatic logic [31:0] exp_rd(int d);
        return (exp_ack(d) != 0) ? mrd[d] : last_rd[d];
    endfunction
    function automatic logic exp_mrd(int d);
        return ph[d] == 1 && !tmo_now(d) && !wr[d][gp[d]];
    endfunction
    function automatic logic exp_mwr(int d);
        return ph[d] == 1 && !tmo_now(d) && wr[d][gp[d]];
    endfunction
    function automatic logic [31:0] exp_maddr(int d);
        return (ph[d] == 1) ? addr[d][gp[d]] : 32'h0;
    endfunction
    function automatic logic [31:0] exp_mwd(int d);
        return (ph[d] == 1) ? wdat[d][gp[d]] : 32'h0;
    endfunction
    function automatic memop_data_type_e exp_typ(int d);
        return (ph[d] == 1) ? typ[d][gp[d]] : WORD;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_ack", d),      32'(o_ack[d]),   32'(exp_ack(d)));
            check($sformatf("dut%0d_err", d),      32'(o_err[d]),   32'(exp_err(d)));
            check($sformatf("dut%0d_rd_data", d),  o_rd[d],         exp_rd(d));
            check($sformatf("dut%0d_busy", d),     32'(o_busy[d]),  32'(ph[d] != 0));
            check($sformatf("dut%0d_mem_rd", d),   32'(o_mrd[d]),   32'(exp_mrd(d)));
            check($sformatf("dut%0d_mem_wr", d),   32'(o_mwr[d]),   32'(exp_mwr(d)));
            check($sformatf("dut%0d_mem_addr", d), o_maddr[d],      exp_maddr(d));
            check($sformatf("dut%0d_mem_wdata", d),o_mwd[d],        exp_mwd(d));
            check($sformatf("dut%0d_mem_type", d), 32'(o_typ[d]),   32'(exp_typ(d)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int err_cyc, rd_cycles;
    bit found, err_rd;

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; wr[d] = '0; mrd[d] = '0; mrdy[d] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                addr[d][p] = '0; wdat[d][p] = '0; typ[d][p] = WORD;
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy_a", 32'(a_busy), 0);
        check("rst_ack_b", 32'(b_ack), 0);
        check("rst_type_a", 32'(a_mtyp), 32'(WORD));
        check("rst_rd_data_b", b_rd, 0);
        tick(); rsn = 1'b1; tick();

        // Fixed priority, both ports request, slow memory
        req[0] = 4'b0011;
        addr[0][0] = 32'h100; addr[0][1] = 32'h200;
        @(negedge clk);
        check("t2_idle_no_strobe", 32'(a_mrd), 0);
        tick(); @(negedge clk);
        check("t2_rd_cycle1", 32'(a_mrd), 1);
        check("t2_addr", a_maddr, 32'h100);
        tick(); tick(); tick();
        mrdy[0] = 1'b1; mrd[0] = 32'hCAFEF00D;
        @(negedge clk);
        check("t2_ack_port0", 32'(a_ack), 32'h1);
        check("t2_rd_data", a_rd, 32'hCAFEF00D);
        tick(); mrdy[0] = 1'b0; req[0][0] = 1'b0;
        @(negedge clk);
        check("t2_idle_gap", 32'(a_busy), 0);
        tick(); @(negedge clk);
        check("t2_port1_addr", a_maddr, 32'h200);
        tick(); mrdy[0] = 1'b1; mrd[0] = 32'h12345678;
        @(negedge clk);
        check("t2_ack_port1", 32'(a_ack), 32'h2);
        tick(); mrdy[0] = 1'b0; req[0] = '0;
        @(negedge clk);
        check("t2_rd_hold", a_rd, 32'h12345678);

        // Misaligned WORD store on port 1
        tick();
        req[0] = 4'b0010; addr[0][1] = 32'h102; wr[0][1] = 1'b1; wdat[0][1] = 32'h55AA55AA;
        @(negedge clk);
        check("t4_no_err_idle", 32'(a_err), 0);
        tick(); @(negedge clk);
        check("t4_err_port1", 32'(a_err), 32'h2);
        check("t4_no_wr", 32'(a_mwr), 0);
        tick(); req[0] = '0; wr[0] = '0;
        @(negedge clk);
        check("t4_back_idle", 32'(a_busy), 0);

        // Watchdog: memory never answers
        tick();
        req[0] = 4'b0001; addr[0][0] = 32'h40;
        found = 1'b0; err_cyc = -1; rd_cycles = 0; err_rd = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_err[0]) begin
                found = 1'b1; err_cyc = c; err_rd = a_mrd;
                break;
            end
            if (a_mrd) rd_cycles++;
            tick();
        end
        check("t5_err_seen", 32'(found), 1);
        check("t5_err_cycle", err_cyc, 8);
        check("t5_rd_dropped", 32'(err_rd), 0);
        check("t5_rd_cycles", rd_cycles, 7);
        tick(); req[0] = '0;

        // Aligned HALF store, then a stray ready while idle
        tick();
        req[0] = 4'b0001; addr[0][0] = 32'h2; wr[0][0] = 1'b1;
        wdat[0][0] = 32'hDEADBEEF; typ[0][0] = HALF;
        @(negedge clk);
        tick(); @(negedge clk);
        check("t6_wr", 32'(a_mwr), 1);
        check("t6_type", 32'(a_mtyp), 32'(HALF));
        check("t6_wdata", a_mwd, 32'hDEADBEEF);
        tick(); mrdy[0] = 1'b1;
        @(negedge clk);
        check("t6_ack", 32'(a_ack), 32'h1);
        tick(); req[0] = '0; wr[0] = '0;
        @(negedge clk);
        check("t6_late_ready_no_ack", 32'(a_ack), 0);
        tick(); @(negedge clk);
        check("t6_late_ready_idle", 32'(a_busy), 0);
        tick(); mrdy[0] = 1'b0;

        // Round-robin: all four ports held, memory always ready
        for (int p = 0; p < 4; p++) addr[1][p] = 32'h1000 + 32'(p) * 32'h10;
        req[1] = 4'b1111; mrdy[1] = 1'b1; mrd[1] = 32'hA5A50000;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) if (b_ack[p]) order.push_back(p);
            if (order.size() == 5) break;
            tick();
        end
        check("t3_ack_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check($sformatf("t3_order%0d", i), order[i], exp_order[i]);
        tick(); req[1] = '0; mrdy[1] = 1'b0;

        // Reset in the middle of an access on both instances
        tick();
        req[0] = 4'b0001; addr[0][0] = 32'h80;
        req[1] = 4'b0100; addr[1][2] = 32'h2000;
        @(negedge clk);
        tick(); @(negedge clk);
        check("t1_a_rd_before", 32'(a_mrd), 1);
        check("t1_b_addr_before", b_maddr, 32'h2000);
        #2; rsn = 1'b0; req[0] = '0; req[1] = '0;
        @(negedge clk);
        check("t1_a_rd_after", 32'(a_mrd), 0);
        check("t1_a_busy_after", 32'(a_busy), 0);
        check("t1_b_rd_after", 32'(b_mrd), 0);
        check("t1_b_ack_after", 32'(b_ack), 0);
        tick(); rsn = 1'b1;
        req[1] = 4'b1111; mrdy[1] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b_ack != 0) begin
                found = 1'b1;
                check("t1_ptr_reset_first_ack", 32'(b_ack), 32'h1);
                break;
            end
            tick();
        end
        check("t1_ack_seen", 32'(found), 1);
        tick(); req[1] = '0; mrdy[1] = 1'b0;

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
